gpio_packet_receiver: RTL
=========================

# gpio_packet_receiver

Serial front end for the OpenRAM test-chip controller. It samples the single-bit GPIO packet line and assembles start/data/parity/stop frames into 86-bit command packets. Each complete, error-free packet is presented to `openram_testchip` as a parallel word with a one-cycle valid strobe, and sits beside the 86-bit logic-analyser packet path. It runs on the same selectable clock as the controller.

## Interface
Parameters:
- `PACKET_WIDTH`, 86, data bits per frame; must equal the controller packet width.
- `SYNC_STAGES`, 2, synchronizer depth on the serial input; minimum 2.

Ports:
- `clk`  input  1  controller clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  receiver armed; tie to the GPIO-select bit of the controller.
- `gpio_in`  input  1  serial line; idles high.
- `packet_o`  output  PACKET_WIDTH  last good packet, MSB = first data bit received.
- `packet_valid`  output  1  one-cycle pulse when `packet_o` is updated.
- `parity_err`  output  1  one-cycle pulse for a frame with bad parity.
- `framing_err`  output  1  one-cycle pulse for a frame with a low stop bit.
- `busy`  output  1  high while a frame is in progress (any state except IDLE).
- `err_count`  output  8  saturating count of parity and framing errors.

## Operation
- Frame layout, one bit per `clk` cycle: start bit (0), PACKET_WIDTH data bits MSB first, even parity bit, stop bit (1).
- `gpio_in` passes through a SYNC_STAGES flop chain to give `rx_s`. The chain resets to all 1s, so reset never produces a false start.
- States: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when `enable` and `rx_s`==0, go to DATA; clear bit counter and running parity.
- DATA: shift `rx_s` into the shift register (shift left, LSB in) and XOR it into the running parity.
  - Increment the counter each cycle.
  - When the counter reaches PACKET_WIDTH-1, the last bit is taken that cycle; go to PARITY.
- PARITY: XOR `rx_s` into the running parity, then go to STOP.
- STOP:
  - `rx_s`==0: pulse `framing_err`, go to WAIT_IDLE. Framing error has priority, so `parity_err` does not also pulse.
  - `rx_s`==1 and running parity==1: pulse `parity_err`, go to IDLE.
  - `rx_s`==1 and parity==0: load `packet_o` from the shift register, pulse `packet_valid`, go to IDLE.
- WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. A low stop bit is never reused as a start bit.
- `packet_o` changes only on a good frame. It holds its value across errors and aborts.
- `enable` low in any state: next state is IDLE, the partial frame is discarded, and no pulses fire.
- `err_count` increments on each `parity_err` or `framing_err` pulse and saturates at 255.
- Reset at any point: the FSM goes to IDLE and the partial frame is dropped.
- Reset values: `packet_o`=0, `packet_valid`=0, `parity_err`=0, `framing_err`=0, `busy`=0, `err_count`=0, synchronizer=all 1s, counter=0.

## Timing
- A `gpio_in` value present in cycle t is at `rx_s` in cycle t+SYNC_STAGES. It is consumed by the FSM at the end of that cycle.
- With the start bit in cycle 0, the stop bit is in cycle PACKET_WIDTH+2 (88).
- `packet_valid`, `parity_err` or `framing_err` is visible in cycle PACKET_WIDTH+2+SYNC_STAGES+1 (91 with defaults). `packet_o` updates in the same cycle.
- Back-to-back frames are accepted. A start bit in the cycle right after the stop bit is detected, because IDLE is entered in the pulse cycle.
- `busy` rises the cycle after the start bit reaches `rx_s`. It falls in the pulse cycle, or stays high through WAIT_IDLE.
- All outputs are registered; there is no combinational path from `gpio_in`.

## Structure
- Package `openram_gpio_rx_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP, WAIT_IDLE);
  - `PACKET_WIDTH_DEFAULT`=86, shared with `openram_testchip`;
  - counter width `$clog2(PACKET_WIDTH)`.
- Sub-module `gpio_bit_sync`: parameterised N-flop synchronizer with a reset value parameter, reusable for the clock-select input.
- Top-level instantiation: in the wrapper, `gpio_in`=`io_in[2]`, and `enable` is the packet-source select.

## Test plan
- Good frame, data = bit85=1, bit0=1, all others 0, parity=0 -> `packet_valid` in cycle 91, `packet_o`=86'h2000000000000000000001, `err_count`=0.
- Same data with parity=1 -> `parity_err` pulse in cycle 91, `packet_o` unchanged (0 after reset), `err_count`=1.
- Good frame but stop bit=0 and line held low for 5 more cycles -> `framing_err` only, `busy` stays high until `rx_s` returns to 1. No new frame starts on the held-low bits.
- Two good frames back-to-back (second start bit in cycle 89) -> two `packet_valid` pulses 89 cycles apart, `packet_o` equals each packet in turn.
- `enable` dropped in cycle 40 of a frame, then re-raised with the line high -> no pulses, `busy`=0 the next cycle. A following good frame is received correctly.
- `reset` asserted in cycle 50 of a frame -> all outputs at reset values the next cycle. 300 consecutive parity-error frames -> `err_count` saturates at 255.

Source files
------------

// File: rtl/openram_gpio_rx_pkg.sv
// Shared definitions for the GPIO packet receiver.
// Holds the FSM state encoding, the default packet width shared with
// openram_testchip, and a helper that sizes the bit counter.
package openram_gpio_rx_pkg;

    localparam int unsigned PACKET_WIDTH_DEFAULT = 86;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_DATA      = 3'd1;
    localparam state_t ST_PARITY    = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_WAIT_IDLE = 3'd4;

    // Bit-counter width for a given packet width (never below 1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(PACKET_WIDTH_DEFAULT);

endpackage

// File: rtl/gpio_bit_sync.sv
// N-flop single-bit synchronizer with a configurable reset value.
// Ports: clk, reset (sync, active-high), d (async input), q (synchronized).
module gpio_bit_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift chain; reset fills every stage with RESET_VAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_packet_receiver.sv
// Serial GPIO packet receiver: start bit, PACKET_WIDTH data bits MSB first,
// even parity, stop bit. Good frames update packet_o with a valid strobe.
// Ports: clk, reset (sync, active-high), enable, gpio_in (idles high);
//        packet_o, packet_valid, parity_err, framing_err, busy, err_count.
module gpio_packet_receiver
    import openram_gpio_rx_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = PACKET_WIDTH_DEFAULT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    gpio_in,
    output logic [PACKET_WIDTH-1:0] packet_o,
    output logic                    packet_valid,
    output logic                    parity_err,
    output logic                    framing_err,
    output logic                    busy,
    output logic [7:0]              err_count
);

    localparam int unsigned CNT_W = cnt_width(PACKET_WIDTH);

    logic                    rx_s;
    state_t                  state;
    state_t                  state_next;
    logic [PACKET_WIDTH-1:0] shift;
    logic [PACKET_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    par;
    logic                    par_next;
    logic                    valid_c;
    logic                    parity_err_c;
    logic                    framing_err_c;

    // Idle-high reset value keeps reset from looking like a start bit.
    gpio_bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_in),
        .q     (rx_s)
    );

    // Next-state and datapath decode.
    always_comb begin
        state_next    = state;
        shift_next    = shift;
        cnt_next      = cnt;
        par_next      = par;
        valid_c       = 1'b0;
        parity_err_c  = 1'b0;
        framing_err_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                    par_next   = 1'b0;
                end
            end
            ST_DATA: begin
                shift_next = {shift[PACKET_WIDTH-2:0], rx_s};
                par_next   = par ^ rx_s;
                cnt_next   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PACKET_WIDTH - 1)) begin
                    state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                par_next   = par ^ rx_s;
                state_next = ST_STOP;
            end
            ST_STOP: begin
                // A low stop bit outranks a parity failure.
                if (!rx_s) begin
                    framing_err_c = 1'b1;
                    state_next    = ST_WAIT_IDLE;
                end else if (par) begin
                    parity_err_c = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    valid_c    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disarming drops any partial frame silently.
        if (!enable) begin
            state_next    = ST_IDLE;
            valid_c       = 1'b0;
            parity_err_c  = 1'b0;
            framing_err_c = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            shift        <= '0;
            cnt          <= '0;
            par          <= 1'b0;
            packet_o     <= '0;
            packet_valid <= 1'b0;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
            busy         <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_next;
            shift        <= shift_next;
            cnt          <= cnt_next;
            par          <= par_next;
            packet_valid <= valid_c;
            parity_err   <= parity_err_c;
            framing_err  <= framing_err_c;
            busy         <= (state_next != ST_IDLE);
            if (valid_c) begin
                packet_o <= shift;
            end
            if ((parity_err_c || framing_err_c) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
